// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a show-ahead byte FIFO.
// Raw PS/2 clock/data pins are synchronized, falling edges of the PS/2
// clock drive an 11-bit deframer (start, 8 data LSB-first, odd parity,
// stop), and good bytes are queued for the memory-mapped read port.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic        ps2_ren,
    output logic [15:0] ps2_data_in,
    output logic        ps2_overflow,
    output logic        ps2_frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronization: bit 0 = PS/2 clock, bit 1 = PS/2 data.
    // Both chains reset to 1 so a released line never looks like an edge.
    // ------------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;

    assign pin_raw = {ps2_dat, ps2_clk};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic meta_q;
        logic sync_q;

        // Two-flop synchronizer for one asynchronous pin
        always_ff @(posedge clk) begin
            if (rst) begin
                meta_q <= 1'b1;
                sync_q <= 1'b1;
            end else begin
                meta_q <= pin_raw[gi];
                sync_q <= meta_q;
            end
        end

        assign pin_sync[gi] = sync_q;
    end

    logic clk_sync;
    logic dat_sync;
    logic clk_prev_q;
    logic fall;

    assign clk_sync = pin_sync[0];
    assign dat_sync = pin_sync[1];

    // Previous synchronized PS/2 clock, for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_sync;
        end
    end

    assign fall = clk_prev_q & ~clk_sync;

    // ------------------------------------------------------------------
    // Framer
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frame_err_q, frame_err_d;
    logic          push_req;

    // Framer state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: deframing on PS/2 falling edges plus a stall timeout
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = '0;
        frame_err_d = frame_err_q;
        push_req    = 1'b0;

        // Idle-time counter only runs while a frame is open
        if (state_q != S_IDLE && !fall) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    if (!dat_sync) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {dat_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    parity_d = dat_sync;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    // Odd parity over data + parity bit, stop bit must be high
                    if (dat_sync && (^{shift_q, parity_q})) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A frame that stalls mid-way is abandoned; the partial byte is lost
        if (state_q != S_IDLE && !fall && tmo_q == TO_LAST) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO. Pointers carry one extra wrap bit so full and
    // empty are distinguishable without a separate count.
    // ------------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push_ok;
    logic        push_drop;
    logic        overflow_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop on an empty FIFO is ignored; a simultaneous pop frees a slot
    // for a push arriving while full.
    assign pop       = ps2_ren & ~fifo_empty;
    assign push_ok   = push_req & (~fifo_full | pop);
    assign push_drop = push_req & fifo_full & ~pop;

    // Storage write; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    // FIFO pointers and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head entry is presented combinationally so the reader sees it in
    // the same cycle it strobes ps2_ren.
    assign ps2_data_in   = fifo_empty ? 16'h0000
                                      : {7'b0, 1'b1, mem_q[rd_ptr_q[AW-1:0]]};
    assign ps2_overflow  = overflow_q;
    assign ps2_frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: a driver produces PS/2 frames and
// logs expected bytes, a reader issues pops, and a monitor compares the
// DUT read port and flags against a queue-based reference FIFO.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic        ps2_ren = 1'b0;
    logic [15:0] ps2_data_in;
    logic        ps2_overflow;
    logic        ps2_frame_err;

    ps2_rx_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .ps2_ren      (ps2_ren),
        .ps2_data_in  (ps2_data_in),
        .ps2_overflow (ps2_overflow),
        .ps2_frame_err(ps2_frame_err)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    int         n_cmp     = 0;
    int         n_bad     = 0;
    bit         mon_en    = 1'b0;
    logic [7:0] push_log [0:4095];
    int         push_wr   = 0;
    int         push_rd   = 0;
    logic [7:0] model_q [$];
    bit         ovf_exp   = 1'b0;
    bit         err_exp   = 1'b0;
    int         flag_req  = 0;
    int         flag_done = 0;

    // Reader control
    int pop_req   = 0;
    int pop_done  = 0;
    bit rd_random = 1'b0;

    // Reader: drives ps2_ren just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_random) begin
                ps2_ren = ($urandom_range(0, 2) == 0);
            end else if (pop_done != pop_req) begin
                ps2_ren = 1'b1;
                pop_done++;
            end else begin
                ps2_ren = 1'b0;
            end
        end
    end

    // Monitor: reference FIFO update and comparisons on every falling edge
    initial begin
        logic [15:0] exp_data;
        forever begin
            @(negedge clk);
            while (push_rd != push_wr) begin
                if (model_q.size() < DEPTH) model_q.push_back(push_log[push_rd]);
                else ovf_exp = 1'b1;
                push_rd++;
            end
            if (mon_en) begin
                exp_data = (model_q.size() != 0) ? {7'b0, 1'b1, model_q[0]} : 16'h0000;
                n_cmp++;
                if (ps2_data_in !== exp_data) begin
                    n_bad++;
                    $display("FAIL data @%0t: got %h expected %h", $time, ps2_data_in, exp_data);
                end
                if (flag_done != flag_req) begin
                    flag_done = flag_req;
                    n_cmp++;
                    if (ps2_overflow !== ovf_exp) begin
                        n_bad++;
                        $display("FAIL overflow @%0t: got %b expected %b", $time, ps2_overflow, ovf_exp);
                    end
                    n_cmp++;
                    if (ps2_frame_err !== err_exp) begin
                        n_bad++;
                        $display("FAIL frame_err @%0t: got %b expected %b", $time, ps2_frame_err, err_exp);
                    end
                end
            end
            if (ps2_ren && model_q.size() != 0) void'(model_q.pop_front());
            if (rst) begin
                model_q.delete();
                ovf_exp = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        err_exp = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        flag_req++;
        @(negedge clk);
        $display("reset done");
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 truncated (no flag change), 4 bad start
    task automatic send_frame(input logic [7:0] d, input int kind, input int nbits,
                              input bit pop_at_push);
        logic [10:0] fr;
        int h;
        h      = $urandom_range(4, 12);
        fr[0]  = (kind == 4);
        fr[8:1] = d;
        fr[9]  = (~^d) ^ (kind == 1);
        fr[10] = (kind != 2);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_dat = fr[i];
            repeat (h) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                @(posedge clk);
                #2;
                if (pop_at_push) pop_req++;
                repeat (2) @(posedge clk);
                if (kind == 0) begin
                    push_log[push_wr] = d;
                    push_wr++;
                end
                repeat (h) @(negedge clk);
            end else begin
                repeat (h) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (h) @(negedge clk);
        if (kind == 1 || kind == 2 || kind == 4) err_exp = 1'b1;
        flag_req++;
        repeat (2) @(negedge clk);
        $display("frame byte=%h kind=%0d bits=%0d pop_at_push=%0d", d, kind, nbits, pop_at_push);
    endtask

    task automatic drain(input int n);
        pop_req += n;
        repeat (n + 6) @(negedge clk);
    endtask

    initial begin
        int r;
        int kind;
        do_reset();

        // Basic good frame, then a single pop
        send_frame(8'h1C, 0, 11, 1'b0);
        drain(1);

        // Parity error: nothing queued, frame_err raised
        send_frame(8'hF0, 1, 11, 1'b0);
        repeat (3) @(negedge clk);

        // Overflow: 17 frames without reads, then drain past empty
        do_reset();
        for (int b = 1; b <= 17; b++) send_frame(8'(b), 0, 11, 1'b0);
        drain(17);

        // Push coinciding with a pop while full, then while at 15 entries
        do_reset();
        for (int b = 0; b < 16; b++) send_frame(8'($urandom_range(0, 255)), 0, 11, 1'b0);
        send_frame(8'hA7, 0, 11, 1'b1);
        drain(1);
        send_frame(8'h3B, 0, 11, 1'b1);
        drain(16);

        // Randomized traffic with random reads (exercises pointer wrap)
        do_reset();
        rd_random = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r    = $urandom_range(0, 9);
            kind = (r < 7) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 4;
            send_frame(8'($urandom_range(0, 255)), kind, (kind == 4) ? 1 : 11, 1'b0);
        end
        @(negedge clk);
        rd_random = 1'b0;
        repeat (3) @(negedge clk);
        drain(20);

        // Truncated frame times out, next frame still received
        do_reset();
        send_frame(8'h00, 3, 5, 1'b0);
        repeat (TMO + 20) @(negedge clk);
        err_exp = 1'b1;
        flag_req++;
        @(negedge clk);
        $display("timeout idle done");
        send_frame(8'h5A, 0, 11, 1'b0);
        drain(1);

        // Reset during DATA with three entries queued
        do_reset();
        send_frame(8'h11, 0, 11, 1'b0);
        send_frame(8'h22, 0, 11, 1'b0);
        send_frame(8'h33, 0, 11, 1'b0);
        send_frame(8'hA5, 3, 4, 1'b0);
        do_reset();
        send_frame(8'h3C, 0, 11, 1'b0);
        drain(2);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
PS/2 device-to-host receiver. It samples the external keyboard clock and data lines, deframes 11-bit PS/2 frames, and queues the received scancode bytes in a show-ahead FIFO. It is the producer behind the memory-mapped PS/2 register at 0xF000. The memory block reads `ps2_data_in` combinationally in the same cycle it asserts `ps2_ren`, and that assertion pops one entry.

Parameters:
- FIFO_DEPTH, 16, number of byte entries; must be a power of two and at least 2.
- TIMEOUT_CYCLES, 100000, idle clk cycles after a falling edge, mid-frame, before the frame is abandoned (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous, idle high
- ps2_dat  in  1  raw PS/2 data pin, asynchronous, idle high
- ps2_ren  in  1  pop strobe from the memory block; one pop per cycle asserted
- ps2_data_in  out  16  read data for the memory block: {7'b0, valid, byte}
- ps2_overflow  out  1  sticky flag: a good frame was dropped because the FIFO was full
- ps2_frame_err  out  1  sticky flag: a frame failed start, parity or stop checks, or timed out

Behaviour:
- Reset: all of the following take effect on the clk edge with rst=1.
  - FIFO is emptied.
  - Framer returns to IDLE.
  - ps2_data_in = 16'h0000.
  - ps2_overflow = 0 and ps2_frame_err = 0.
  - Both synchronizers are loaded with 1.
  - A frame in progress when reset is applied is discarded.
- Input synchronization:
  - ps2_clk and ps2_dat each pass through a 2-FF synchronizer.
  - A falling edge is detected when the previous synchronized clk value is 1 and the current value is 0.
  - Data is sampled on the synchronized value in the falling-edge cycle.
  - Latency from pin to edge detection is 3 clk cycles.
- Framer FSM:
  - IDLE: on a falling edge, if data = 0 go to DATA with bit_cnt = 0; if data = 1 set frame_err and stay in IDLE.
  - DATA: on each falling edge, shift data in LSB-first; after bit_cnt reaches 8 go to PARITY.
  - PARITY: on a falling edge, capture the parity bit and go to STOP.
  - STOP: on a falling edge the frame is good if stop = 1 and the XOR of the 8 data bits with the parity bit is 1 (odd parity).
    - Good frame: push the byte.
    - Bad frame: set frame_err and do not push.
    - In both cases return to IDLE.
  - Timeout:
    - In any state other than IDLE, a cycle counter is cleared on every falling edge.
    - When the counter reaches TIMEOUT_CYCLES-1 with no edge, the FSM goes to IDLE, sets frame_err, and the partial byte is discarded.
- FIFO (show-ahead):
  - ps2_data_in is combinational from the head entry: {7'b0, 1'b1, head} when not empty, 16'h0000 when empty.
  - The push takes effect at the clk edge in the STOP-state falling-edge cycle; the byte is visible on ps2_data_in the following cycle.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - Full when the low bits of the pointers are equal and the MSBs differ; empty when the pointers are equal.
- Pop/push edge cases:
  - ps2_ren while empty: no effect; pointers unchanged.
  - Push and pop in the same cycle, not empty: both occur and the count is unchanged.
  - Push and pop in the same cycle while full: the pop frees a slot, so the push succeeds and ps2_overflow is not set.
  - Push while full with no pop: the byte is dropped and ps2_overflow is set.
  - Push and pop in the same cycle while empty: the push occurs and the pop is ignored, leaving count = 1.
- Sticky flags: ps2_overflow and ps2_frame_err are cleared only by rst.

Test Plan:
- Send frame for byte 0x1C (bits LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) -> ps2_data_in = 16'h011C one cycle after the stop falling edge; pulse ps2_ren -> 16'h0000 on the next cycle.
- Send byte 0xF0 with parity forced to 1 -> no push, ps2_data_in stays 16'h0000, ps2_frame_err = 1.
- Send 17 good bytes 0x01..0x11 with no reads -> ps2_overflow = 1; 16 pops return 0x0101..0x0110 in order, then 16'h0000.
- FIFO holding 15 entries; hold ps2_ren high across the 16th push cycle -> push accepted, count stays 15, ps2_overflow = 0; FIFO pointers wrap correctly over 40 push/pop cycles.
- Send start bit plus 4 data bits, then idle TIMEOUT_CYCLES -> frame_err = 1; a subsequent good 0x5A frame yields 16'h015A.
- Assert rst during the DATA state with 3 entries queued -> after reset ps2_data_in = 16'h0000 and both flags = 0; the next full frame is received correctly.
